rc4_session_ctrl: RTL and testbench
===================================

// Module: rc4_session_ctrl
// PURPOSE
//  Session sequencer for the RC4 engine. Loads a key into a local buffer and
//  starts KSA, then serves the key back to KSA by index. After KSA it runs
//  msg_len plaintext bytes: one PRNG keystream request per byte, output
//  cipher byte = pt ^ ks. Sits between the host byte interfaces and the
//  ksa/prng/sarr_mem datapath.
// PARAMETERS
//  KEY_MAX  16  max key bytes held in local key buffer (power of 2, 2..256)
//  LEN_W    16  width of message length counter
// PORTS
//  clk        in   1                 system clock, rising edge
//  rst        in   1                 synchronous reset, active-high
//  start      in   1                 begin session; sampled in IDLE only
//  key_len    in   $clog2(KEY_MAX)+1 key length in bytes, sampled with start
//  msg_len    in   LEN_W             message bytes, sampled with start
//  abort      in   1                 terminate session
//  key_vld    in   1                 key byte valid
//  key_byte   in   8                 key byte
//  key_rdy    out  1                 key byte accepted when key_vld & key_rdy
//  ksa_start  out  1                 one-cycle pulse to KSA
//  ksa_done   in   1                 KSA complete, one-cycle pulse
//  key_idx    in   8                 KSA key read index (i mod key_len by KSA)
//  key_data   out  8                 key_buf[key_idx mod KEY_MAX], comb read
//  ks_req     out  1                 one-cycle pulse: generate next keystream byte
//  ks_vld     in   1                 keystream byte valid, one-cycle pulse
//  ks_byte    in   8                 keystream byte
//  pt_vld     in   1                 plaintext byte valid
//  pt_byte    in   8                 plaintext byte
//  pt_rdy     out  1                 plaintext accepted when pt_vld & pt_rdy
//  ct_vld     out  1                 cipher byte valid, held until ct_rdy
//  ct_byte    out  8                 cipher byte
//  ct_rdy     in   1                 downstream ready
//  busy       out  1                 state != IDLE
//  done       out  1                 one-cycle pulse, session completed normally
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; counters 0; key buffer contents don't-care.
//  States: IDLE -> LOAD -> KSA -> WAIT_PT -> WAIT_KS -> OUT -> (WAIT_PT | FIN) -> IDLE.
//  IDLE: on start: latch key_len, msg_len; zero key_cnt, byte_cnt; ->LOAD.
//    start with key_len==0 or key_len>KEY_MAX is ignored (stay IDLE, no pulse).
//  LOAD: key_rdy=1. Each handshake writes key_buf[key_cnt], key_cnt++.
//    Last byte accepted (key_cnt==key_len-1) -> KSA; ksa_start pulses the
//    first cycle in KSA (exactly one pulse per session).
//  KSA: waits for ksa_done. If msg_len==0 -> FIN, else -> WAIT_PT.
//    ksa_done outside KSA is ignored.
//  WAIT_PT: pt_rdy=1. On handshake latch pt_byte, pulse ks_req the same cycle
//    as the handshake (registered pt_rdy drops next cycle) -> WAIT_KS.
//  WAIT_KS: on ks_vld, ct_byte <= pt_reg ^ ks_byte, ct_vld<=1 -> OUT.
//    ks_vld in the same cycle as entry is accepted.
//  OUT: ct_vld/ct_byte held stable until ct_rdy. On ct_vld&ct_rdy: byte_cnt++,
//    ct_vld<=0; if byte_cnt==msg_len-1 -> FIN else -> WAIT_PT.
//    Min throughput: 1 byte per 3 cycles (pt handshake, ks_vld, ct handshake).
//  FIN: done=1 for one cycle -> IDLE. busy=0 from next cycle.
//  abort (any non-IDLE state): next cycle IDLE, all outputs 0, no done pulse;
//    ct byte held in OUT is dropped. abort in IDLE is a no-op; abort beats start.
//  rst overrides everything at any state, incl. mid-stream.
//  start while busy is ignored. Only one ks_req outstanding at any time.
//  key_data: combinational key_buf[key_idx[$clog2(KEY_MAX)-1:0]], valid in
//    all states; buffer retains last key after session.
//  byte_cnt wraps never: the msg_len compare is exact; max message 2^LEN_W-1.
// TESTING
//  rst; start key_len=3 key {01,02,03} msg_len=2 -> key_rdy 3 cycles, 1 ksa_start pulse.
//  After ksa_done, pt {00,FF}, ks {A5,5A} -> ct {A5,A5}, done pulse after 2nd ct.
//  Hold ct_rdy=0 for 10 cycles in OUT -> ct_vld/ct_byte stable, no 2nd ks_req.
//  msg_len=0 -> after ksa_done, done pulse with no ks_req/ct_vld; key_len=0 ignored.
//  abort while in WAIT_KS -> IDLE next cycle, ct_vld=0, busy=0, no done.
//  start in OUT and stray ksa_done in STREAM -> no state effect; rst mid-LOAD -> all 0.

Source files
------------

// File: rtl/rc4_session_ctrl_if.sv
// Byte-level handshake bundle between the host/RC4 datapath and rc4_session_ctrl.
// The master side is the host plus KSA/PRNG engines; the slave side is the sequencer.
interface rc4_session_ctrl_if #(
  parameter int unsigned KEY_MAX = 16,
  parameter int unsigned LEN_W   = 16
);
  localparam int unsigned KLW = $clog2(KEY_MAX) + 1;

  logic             start;
  logic [KLW-1:0]   key_len;
  logic [LEN_W-1:0] msg_len;
  logic             abort;
  logic             key_vld;
  logic [7:0]       key_byte;
  logic             key_rdy;
  logic             ksa_start;
  logic             ksa_done;
  logic [7:0]       key_idx;
  logic [7:0]       key_data;
  logic             ks_req;
  logic             ks_vld;
  logic [7:0]       ks_byte;
  logic             pt_vld;
  logic [7:0]       pt_byte;
  logic             pt_rdy;
  logic             ct_vld;
  logic [7:0]       ct_byte;
  logic             ct_rdy;
  logic             busy;
  logic             done;

  modport master (
    output start, key_len, msg_len, abort, key_vld, key_byte, ksa_done,
           key_idx, ks_vld, ks_byte, pt_vld, pt_byte, ct_rdy,
    input  key_rdy, ksa_start, key_data, ks_req, pt_rdy, ct_vld, ct_byte,
           busy, done
  );

  modport slave (
    input  start, key_len, msg_len, abort, key_vld, key_byte, ksa_done,
           key_idx, ks_vld, ks_byte, pt_vld, pt_byte, ct_rdy,
    output key_rdy, ksa_start, key_data, ks_req, pt_rdy, ct_vld, ct_byte,
           busy, done
  );
endinterface

// File: rtl/rc4_session_ctrl.sv
// RC4 session sequencer: buffers the key, kicks KSA and serves key bytes back
// by index, then streams msg_len plaintext bytes through the PRNG keystream.
module rc4_session_ctrl #(
  parameter int unsigned KEY_MAX = 16,
  parameter int unsigned LEN_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  rc4_session_ctrl_if.slave  sif
);
  localparam int unsigned AW  = $clog2(KEY_MAX);
  localparam int unsigned KLW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_KSA, S_WAIT_PT, S_WAIT_KS, S_OUT, S_FIN
  } state_t;

  state_t           state_q, state_d;
  logic [KLW-1:0]   key_len_q, key_len_d;
  logic [KLW-1:0]   key_cnt_q, key_cnt_d;
  logic [LEN_W-1:0] msg_len_q, msg_len_d;
  logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]       pt_q, pt_d;
  logic [7:0]       ct_byte_q, ct_byte_d;
  logic             ksa_start_q, ksa_start_d;
  logic             key_we;
  logic [7:0]       key_buf [KEY_MAX];

  // Next-state and datapath update; abort from any busy state overrides all.
  always_comb begin
    state_d     = state_q;
    key_len_d   = key_len_q;
    key_cnt_d   = key_cnt_q;
    msg_len_d   = msg_len_q;
    byte_cnt_d  = byte_cnt_q;
    pt_d        = pt_q;
    ct_byte_d   = ct_byte_q;
    ksa_start_d = 1'b0;
    key_we      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (sif.start && !sif.abort && (sif.key_len != '0) &&
            (sif.key_len <= KLW'(KEY_MAX))) begin
          key_len_d  = sif.key_len;
          msg_len_d  = sif.msg_len;
          key_cnt_d  = '0;
          byte_cnt_d = '0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        if (sif.key_vld) begin
          key_we    = 1'b1;
          key_cnt_d = key_cnt_q + KLW'(1);
          if (key_cnt_q == key_len_q - KLW'(1)) begin
            state_d     = S_KSA;
            ksa_start_d = 1'b1;
          end
        end
      end
      S_KSA: begin
        if (sif.ksa_done) begin
          state_d = (msg_len_q == '0) ? S_FIN : S_WAIT_PT;
        end
      end
      S_WAIT_PT: begin
        if (sif.pt_vld) begin
          pt_d    = sif.pt_byte;
          state_d = S_WAIT_KS;
        end
      end
      S_WAIT_KS: begin
        if (sif.ks_vld) begin
          ct_byte_d = pt_q ^ sif.ks_byte;
          state_d   = S_OUT;
        end
      end
      S_OUT: begin
        if (sif.ct_rdy) begin
          byte_cnt_d = byte_cnt_q + LEN_W'(1);
          ct_byte_d  = '0;
          state_d    = (byte_cnt_q == msg_len_q - LEN_W'(1)) ? S_FIN : S_WAIT_PT;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort drops everything, including a cipher byte still held in OUT.
    if (sif.abort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      ct_byte_d   = '0;
      ksa_start_d = 1'b0;
      key_we      = 1'b0;
    end
  end

  // Control/datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      key_len_q   <= '0;
      key_cnt_q   <= '0;
      msg_len_q   <= '0;
      byte_cnt_q  <= '0;
      pt_q        <= '0;
      ct_byte_q   <= '0;
      ksa_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_len_q   <= key_len_d;
      key_cnt_q   <= key_cnt_d;
      msg_len_q   <= msg_len_d;
      byte_cnt_q  <= byte_cnt_d;
      pt_q        <= pt_d;
      ct_byte_q   <= ct_byte_d;
      ksa_start_q <= ksa_start_d;
    end
  end

  // Key buffer write; contents are not reset and persist after a session.
  always_ff @(posedge clk) begin
    if (key_we && !rst) begin
      key_buf[key_cnt_q[AW-1:0]] <= sif.key_byte;
    end
  end

  // Only the low index bits address the buffer; the rest wrap by design.
  if (AW < 8) begin : g_idx_unused
    logic unused_idx_hi;
    assign unused_idx_hi = ^sif.key_idx[7:AW];
  end

  assign sif.key_data  = key_buf[sif.key_idx[AW-1:0]];
  assign sif.key_rdy   = (state_q == S_LOAD);
  assign sif.pt_rdy    = (state_q == S_WAIT_PT);
  assign sif.ks_req    = (state_q == S_WAIT_PT) && sif.pt_vld;
  assign sif.ct_vld    = (state_q == S_OUT);
  assign sif.ct_byte   = ct_byte_q;
  assign sif.ksa_start = ksa_start_q;
  assign sif.busy      = (state_q != S_IDLE);
  assign sif.done      = (state_q == S_FIN);
endmodule

// File: tb/tb_rc4_session_ctrl.sv
// Bench for rc4_session_ctrl: plays host, KSA and PRNG; expected cipher bytes
// are pt ^ ks from bench-held byte lists, pulse counts from session rules.
module tb_rc4_session_ctrl;
  localparam int unsigned KEY_MAX = 16;
  localparam int unsigned LEN_W   = 16;
  localparam int unsigned KLW     = $clog2(KEY_MAX) + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rc4_session_ctrl_if #(.KEY_MAX(KEY_MAX), .LEN_W(LEN_W)) bus();

  rc4_session_ctrl #(.KEY_MAX(KEY_MAX), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .sif (bus)
  );

  int checks = 0;
  int errors = 0;
  int n_ksa_start = 0;
  int n_ks_req = 0;
  int n_done = 0;

  logic [7:0] key_m [KEY_MAX];
  logic [7:0] pt_m [$];
  logic [7:0] ks_m [$];

  // Pulse counters, sampled at the active edge where the pulse is consumed.
  always @(posedge clk) begin
    if (bus.ksa_start) n_ksa_start++;
    if (bus.ks_req)    n_ks_req++;
    if (bus.done)      n_done++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] outs();
    return {bus.busy, bus.key_rdy, bus.pt_rdy, bus.ct_vld,
            bus.ksa_start, bus.ks_req, bus.done};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0; bus.key_len = '0; bus.msg_len = '0; bus.abort = 1'b0;
    bus.key_vld = 1'b0; bus.key_byte = '0; bus.ksa_done = 1'b0;
    bus.key_idx = '0; bus.ks_vld = 1'b0; bus.ks_byte = '0;
    bus.pt_vld = 1'b0; bus.pt_byte = '0; bus.ct_rdy = 1'b0;
  endtask

  task automatic fill(input int klen, input int mlen);
    for (int k = 0; k < klen; k++) key_m[k] = 8'($urandom);
    pt_m.delete();
    ks_m.delete();
    for (int i = 0; i < mlen; i++) begin
      pt_m.push_back(8'($urandom));
      ks_m.push_back(8'($urandom));
    end
  endtask

  task automatic run_session(input int klen, input int mlen, input int stall,
                             input int abort_at, input bit gaps);
    int a0, r0, d0, dly, s;
    logic [7:0] expct;
    a0 = n_ksa_start; r0 = n_ks_req; d0 = n_done;

    bus.start = 1'b1; bus.key_len = KLW'(klen); bus.msg_len = LEN_W'(mlen);
    cyc();
    bus.start = 1'b0;
    chk("load_busy", 32'(bus.busy), 32'(1));

    for (int k = 0; k < klen; k++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        bus.key_vld = 1'b0;
        cyc();
      end
      chk("key_rdy", 32'(bus.key_rdy), 32'(1));
      bus.key_vld = 1'b1; bus.key_byte = key_m[k];
      cyc();
    end
    bus.key_vld = 1'b0;
    chk("ksa_start_first", 32'({bus.ksa_start, bus.key_rdy}), 32'(2'b10));

    for (int j = 0; j < klen; j++) begin
      bus.key_idx = 8'(j + KEY_MAX * $urandom_range(0, 256 / KEY_MAX - 1));
      #1;
      chk("key_data", 32'(bus.key_data), 32'(key_m[j]));
    end
    cyc();
    chk("ksa_start_gone", 32'(bus.ksa_start), 32'(0));

    bus.ksa_done = 1'b1;
    cyc();
    bus.ksa_done = 1'b0;

    if (mlen == 0) begin
      chk("done_nomsg", 32'({bus.busy, bus.done, bus.ct_vld, bus.pt_rdy}), 32'(4'b1100));
    end

    for (int i = 0; i < mlen; i++) begin
      if (gaps) begin
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
          bus.pt_vld = 1'b0;
          cyc();
        end
      end
      chk("pt_rdy", 32'(bus.pt_rdy), 32'(1));
      bus.pt_vld = 1'b1; bus.pt_byte = pt_m[i];
      #1;
      chk("ks_req_pulse", 32'(bus.ks_req), 32'(1));
      cyc();
      bus.pt_vld = 1'b0;
      chk("wait_ks", 32'({bus.pt_rdy, bus.ks_req, bus.ct_vld}), 32'(0));

      if (i == abort_at) begin
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
        chk("abort_outs", 32'({outs(), bus.ct_byte}), 32'(0));
        cyc();
        chk("abort_no_done", 32'(n_done - d0), 32'(0));
        chk("abort_idle", 32'(bus.busy), 32'(0));
        return;
      end

      dly = gaps ? int'($urandom_range(0, 3)) : 0;
      for (int g = 0; g < dly; g++) begin
        bus.ksa_done = 1'b1;          // stray, must be ignored
        cyc();
        bus.ksa_done = 1'b0;
        chk("ks_wait_hold", 32'({bus.ct_vld, bus.busy, bus.pt_rdy}), 32'(3'b010));
      end

      bus.ks_vld = 1'b1; bus.ks_byte = ks_m[i];
      cyc();
      bus.ks_vld = 1'b0;
      expct = pt_m[i] ^ ks_m[i];
      chk("ct_vld", 32'(bus.ct_vld), 32'(1));
      chk("ct_byte", 32'(bus.ct_byte), 32'(expct));

      s = (i == 0) ? stall : (gaps ? int'($urandom_range(0, 2)) : 0);
      for (int c = 0; c < s; c++) begin
        if (c == 0) begin
          bus.start = 1'b1; bus.key_len = KLW'(1); bus.msg_len = '0;
        end
        cyc();
        bus.start = 1'b0;
        chk("stall_hold", 32'({bus.busy, bus.ct_vld, bus.ct_byte}), 32'({2'b11, expct}));
        chk("stall_no_ks_req", 32'(n_ks_req - r0), 32'(i + 1));
      end

      bus.ct_rdy = 1'b1;
      cyc();
      bus.ct_rdy = 1'b0;
      if (i == mlen - 1)
        chk("done_pulse", 32'({bus.busy, bus.done, bus.ct_vld}), 32'(3'b110));
      else
        chk("next_pt", 32'({bus.pt_rdy, bus.ct_vld, bus.done}), 32'(3'b100));
    end

    cyc();
    chk("idle_after", 32'({bus.busy, bus.done}), 32'(0));
    chk("ksa_start_count", 32'(n_ksa_start - a0), 32'(1));
    chk("ks_req_count", 32'(n_ks_req - r0), 32'(mlen));
    chk("done_count", 32'(n_done - d0), 32'(1));
    bus.key_idx = 8'(klen - 1);
    #1;
    chk("key_retained", 32'(bus.key_data), 32'(key_m[klen - 1]));
    cyc();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    cyc();
    cyc();
    chk("reset_outs", 32'({outs(), bus.ct_byte}), 32'(0));
    rst = 1'b0;
    cyc();
    chk("idle_outs", 32'({outs(), bus.ct_byte}), 32'(0));

    // Directed: key {01,02,03}, pt {00,FF}, ks {A5,5A}, long ct stall.
    key_m[0] = 8'h01; key_m[1] = 8'h02; key_m[2] = 8'h03;
    pt_m = '{8'h00, 8'hFF};
    ks_m = '{8'hA5, 8'h5A};
    run_session(3, 2, 10, -1, 1'b0);

    // Empty message: done right after KSA, no keystream traffic.
    fill(2, 0);
    run_session(2, 0, 0, -1, 1'b0);

    // Illegal key lengths and abort-with-start are ignored in IDLE.
    bus.start = 1'b1; bus.key_len = '0; bus.msg_len = LEN_W'(3);
    cyc();
    chk("keylen0_ignored", 32'({outs(), bus.ct_byte}), 32'(0));
    bus.key_len = KLW'(KEY_MAX + 1);
    cyc();
    chk("keylen_big_ignored", 32'(bus.busy), 32'(0));
    bus.key_len = KLW'(4); bus.abort = 1'b1;
    cyc();
    chk("abort_beats_start", 32'(bus.busy), 32'(0));
    idle_inputs();
    cyc();

    // Abort while waiting for keystream on the second byte.
    fill(4, 3);
    run_session(4, 3, 0, 1, 1'b0);
    cyc();

    // Reset in the middle of key loading.
    bus.start = 1'b1; bus.key_len = KLW'(4); bus.msg_len = LEN_W'(1);
    cyc();
    bus.start = 1'b0;
    bus.key_vld = 1'b1; bus.key_byte = 8'h77;
    cyc();
    chk("mid_load_busy", 32'({bus.busy, bus.key_rdy}), 32'(2'b11));
    rst = 1'b1; bus.key_vld = 1'b0;
    cyc();
    rst = 1'b0;
    chk("rst_mid_load", 32'({outs(), bus.ct_byte}), 32'(0));
    cyc();
    chk("rst_mid_load_idle", 32'(bus.busy), 32'(0));

    // Randomized sessions, including minimum and maximum key lengths.
    for (int n = 0; n < 8; n++) begin
      int klen, mlen;
      klen = (n == 0) ? KEY_MAX : (n == 1) ? 1 : int'($urandom_range(1, KEY_MAX));
      mlen = int'($urandom_range(0, 6));
      fill(klen, mlen);
      run_session(klen, mlen, int'($urandom_range(0, 4)), -1, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
